// File: rtl/display_pkg.sv
// display_pkg: page encodings and display width shared by the display source select block.
`default_nettype none

package display_pkg;

    localparam int DISPLAY_W = 16;

    typedef enum logic [1:0] {
        PAGE_PC  = 2'b00,
        PAGE_RS  = 2'b01,
        PAGE_RT  = 2'b10,
        PAGE_ALU = 2'b11
    } page_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a stable-level debouncer; the level flips
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic in,
    output logic out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             in_meta;
    logic             in_sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            in_meta <= 1'b0;
            in_sync <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
        end else begin
            in_meta <= in;
            in_sync <= in_meta;
            // Any agreement restarts the window, so bounces shorter than it never count.
            if (in_sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out = stable;

endmodule

`default_nettype wire

// File: rtl/display_source_select.sv
// display_source_select: switch-selected debug page register, scan clock divider and step debounce.
// Optional DISPLAY_HOLD_EN adds a synchronised Hold input that freezes the display word.
`default_nettype none

module display_source_select
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 BtnStep,
    input  logic [1:0]           SW,
    input  logic [31:0]          PC,
    input  logic [31:0]          NextPC,
    input  logic [4:0]           RsAddr,
    input  logic [31:0]          RsData,
    input  logic [4:0]           RtAddr,
    input  logic [31:0]          RtData,
    input  logic [31:0]          ALUResult,
    input  logic [31:0]          DB,
    output logic [DISPLAY_W-1:0] display,
    output logic                 ScanCLK,
    output logic                 CPUCLK
`ifdef DISPLAY_HOLD_EN
    ,
    input  logic                 Hold
`endif
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [1:0]           sw_meta;
    page_t                sw_sync;
    logic [DISPLAY_W-1:0] page_word;
    logic [SCAN_W-1:0]    scan_cnt;
    logic                 unused_hi;

    // Only the low byte of each 32-bit bus is ever shown.
    assign unused_hi = ^{PC[31:8], NextPC[31:8], RsData[31:8], RtData[31:8],
                         ALUResult[31:8], DB[31:8]};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sw_meta <= 2'b00;
            sw_sync <= PAGE_PC;
        end else begin
            sw_meta <= SW;
            sw_sync <= page_t'(sw_meta);
        end
    end

    always_comb begin
        page_word = '0;
        case (sw_sync)
            PAGE_PC:  page_word = {PC[7:0], NextPC[7:0]};
            PAGE_RS:  page_word = {3'b000, RsAddr, RsData[7:0]};
            PAGE_RT:  page_word = {3'b000, RtAddr, RtData[7:0]};
            PAGE_ALU: page_word = {ALUResult[7:0], DB[7:0]};
            default:  page_word = '0;
        endcase
    end

`ifdef DISPLAY_HOLD_EN
    logic hold_meta;
    logic hold_sync;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hold_meta <= 1'b0;
            hold_sync <= 1'b0;
            display   <= '0;
        end else begin
            hold_meta <= Hold;
            hold_sync <= hold_meta;
            if (!hold_sync) begin
                display <= page_word;
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            display <= '0;
        end else begin
            display <= page_word;
        end
    end
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
            ScanCLK  <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            ScanCLK  <= ~ScanCLK;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .CLK   (CLK),
        .Reset (Reset),
        .in    (BtnStep),
        .out   (CPUCLK)
    );

endmodule

`default_nettype wire

// File: tb/tb_display_source_select.sv
// tb_display_source_select: directed bench with a display scoreboard queue, DEBOUNCE_CYCLES=4, SCAN_DIV=3.
`default_nettype none

module tb_display_source_select;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        BtnStep;
    logic [1:0]  SW;
    logic [31:0] PC, NextPC, RsData, RtData, ALUResult, DB;
    logic [4:0]  RsAddr, RtAddr;
    logic [15:0] display;
    logic        ScanCLK;
    logic        CPUCLK;
`ifdef DISPLAY_HOLD_EN
    logic        Hold;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    display_source_select #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV       (3)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .BtnStep   (BtnStep),
        .SW        (SW),
        .PC        (PC),
        .NextPC    (NextPC),
        .RsAddr    (RsAddr),
        .RsData    (RsData),
        .RtAddr    (RtAddr),
        .RtData    (RtData),
        .ALUResult (ALUResult),
        .DB        (DB),
        .display   (display),
        .ScanCLK   (ScanCLK),
        .CPUCLK    (CPUCLK)
`ifdef DISPLAY_HOLD_EN
        ,
        .Hold      (Hold)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Push the expected word when stimulus is applied, pop it once the DUT latency has elapsed.
    task automatic expect_display(input string tag, input logic [15:0] exp, input int lat);
        logic [15:0] e;
        exp_q.push_back(exp);
        cycles(lat);
        e = exp_q.pop_front();
        vectors++;
        assert (display === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, display, e);
        end
    endtask

    initial begin
        Reset = 1'b0; BtnStep = 1'b0; SW = 2'b00;
        PC = '0; NextPC = '0; RsAddr = '0; RsData = '0;
        RtAddr = '0; RtData = '0; ALUResult = '0; DB = '0;
`ifdef DISPLAY_HOLD_EN
        Hold = 1'b0;
`endif
        cycles(2);
        expect_display("reset_display", 16'h0000, 0);
        chk1("reset_scanclk", ScanCLK, 1'b0);
        chk1("reset_cpuclk", CPUCLK, 1'b0);

        // Free-running scan clock: toggles after every 3rd edge, starting low.
        Reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycles(1);
            chk1($sformatf("scan_k%0d", k), ScanCLK, ((k / 3) % 2) == 1);
        end

        PC = 32'h0000_0014; NextPC = 32'h0000_0018;
        expect_display("page_pc", 16'h1418, 3);

        SW = 2'b11; ALUResult = 32'h0000_00AB; DB = 32'h0000_00CD;
        expect_display("sw_lat_2", 16'h1418, 2);
        expect_display("sw_lat_3", 16'hABCD, 1);

        ALUResult = 32'hFFFF_FF12; DB = 32'h0000_0034;
        expect_display("data_lat_1", 16'h1234, 1);

        SW = 2'b01; RsAddr = 5'd9; RsData = 32'hDEAD_BE7F;
        expect_display("page_rs", 16'h097F, 3);

        SW = 2'b10; RtAddr = 5'd31; RtData = 32'hABCD_0001;
        expect_display("page_rt", 16'h1F01, 3);

        // Bounces of 1..3 cycles must never reach CPUCLK.
        for (int w = 1; w <= 3; w++) begin
            repeat (2) begin
                BtnStep = 1'b1;
                for (int c = 0; c < w; c++) begin
                    cycles(1);
                    chk1($sformatf("bounce_w%0d_hi", w), CPUCLK, 1'b0);
                end
                BtnStep = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    cycles(1);
                    chk1($sformatf("bounce_w%0d_lo", w), CPUCLK, 1'b0);
                end
            end
        end
        cycles(4);
        chk1("bounce_settle", CPUCLK, 1'b0);

        BtnStep = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            cycles(1);
            chk1($sformatf("step_edge%0d", e), CPUCLK, e == 6);
        end

        // Asynchronous reset in the middle of a cycle.
        cycles(1);
        #2 Reset = 1'b0;
        #1;
        expect_display("async_rst_display", 16'h0000, 0);
        chk1("async_rst_scanclk", ScanCLK, 1'b0);
        chk1("async_rst_cpuclk", CPUCLK, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            cycles(1);
            chk1($sformatf("rst_held_edge%0d", e), CPUCLK, e == 6);
        end

`ifdef DISPLAY_HOLD_EN
        SW = 2'b00; PC = 32'h0000_0014; NextPC = 32'h0000_0018;
        expect_display("hold_pre", 16'h1418, 3);
        Hold = 1'b1;
        cycles(3);
        SW = 2'b11; PC = 32'h0000_0055;
        expect_display("hold_frozen", 16'h1418, 5);
        Hold = 1'b0;
        expect_display("hold_release", 16'h1234, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
